// File: rtl/x_corr_lags_if.sv
// Sample/result handshake bundle for x_corr_lags.
// THRESHOLD_DETECT_EN adds the threshold input and the detect flag.
interface x_corr_lags_if #(
  parameter int xi_bits      = 12,
  parameter int xq_bits      = 12,
  parameter int yi_bits      = 12,
  parameter int yq_bits      = 12,
  parameter int lag_bits     = 4,
  parameter int out_max_bits = 16
);
  logic signed [xi_bits-1:0] xi;
  logic signed [xq_bits-1:0] xq;
  logic signed [yi_bits-1:0] yi;
  logic signed [yq_bits-1:0] yq;
  logic                      m_axis_tvalid;
  logic                      s_axis_tready;
  logic [out_max_bits-1:0]   out_max;
  logic [lag_bits-1:0]       index;
  logic                      s_axis_tvalid;
  logic                      m_axis_tready;
  logic                      busy;
`ifdef THRESHOLD_DETECT_EN
  logic [out_max_bits-1:0]   threshold;
  logic                      detect;

  modport master (
    output xi, xq, yi, yq, m_axis_tvalid, m_axis_tready, threshold,
    input  s_axis_tready, out_max, index, s_axis_tvalid, busy, detect
  );

  modport slave (
    input  xi, xq, yi, yq, m_axis_tvalid, m_axis_tready, threshold,
    output s_axis_tready, out_max, index, s_axis_tvalid, busy, detect
  );
`else
  modport master (
    output xi, xq, yi, yq, m_axis_tvalid, m_axis_tready,
    input  s_axis_tready, out_max, index, s_axis_tvalid, busy
  );

  modport slave (
    input  xi, xq, yi, yq, m_axis_tvalid, m_axis_tready,
    output s_axis_tready, out_max, index, s_axis_tvalid, busy
  );
`endif
endinterface

// File: rtl/x_corr_lags.sv
// Multi-lag complex cross-correlator: accumulates x*conj(y) per lag, reports peak |acc|^2 and its lag.
// Optional macro THRESHOLD_DETECT_EN adds a registered detect flag (out_max >= threshold).
module x_corr_lags #(
  parameter int xi_bits             = 12,
  parameter int xq_bits             = 12,
  parameter int yi_bits             = 12,
  parameter int yq_bits             = 12,
  parameter int acc_bits            = 32,
  parameter int corr_length         = 8,
  parameter int length_counter_bits = 3,
  parameter int num_lags            = 16,
  parameter int lag_bits            = 4,
  parameter int out_shift           = 16,
  parameter int out_max_bits        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  x_corr_lags_if.slave bus
);
  localparam int mag_bits = 2 * acc_bits;
  localparam logic [length_counter_bits-1:0] last_sample = length_counter_bits'(corr_length - 1);
  localparam logic [lag_bits-1:0]            last_lag    = lag_bits'(num_lags - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, MAG1, MAG2, DONE} state_t;

  state_t                         state;
  logic signed [acc_bits-1:0]     acc_i;
  logic signed [acc_bits-1:0]     acc_q;
  logic [length_counter_bits-1:0] sample_cnt;
  logic [lag_bits-1:0]            lag;
  logic [mag_bits-1:0]            mag;
  logic [mag_bits-1:0]            max_mag;
  logic [lag_bits-1:0]            max_idx;

  logic                               accept;
  logic signed [xi_bits+yi_bits-1:0]  p_ii;
  logic signed [xq_bits+yq_bits-1:0]  p_qq;
  logic signed [xq_bits+yi_bits-1:0]  p_qi;
  logic signed [xi_bits+yq_bits-1:0]  p_iq;
  logic signed [acc_bits-1:0]         acc_i_next;
  logic signed [acc_bits-1:0]         acc_q_next;
  logic signed [mag_bits-1:0]         wide_i;
  logic signed [mag_bits-1:0]         wide_q;
  logic [mag_bits-1:0]                mag_calc;
  logic                               take_new;
  logic [mag_bits-1:0]                best_mag;
  logic [lag_bits-1:0]                best_idx;
  logic [mag_bits-1:0]                best_shifted;
  logic [out_max_bits-1:0]            best_sat;

  // Best-so-far includes the lag being closed in MAG2, so the final result is ready on that edge.
  always_comb begin
    accept       = bus.m_axis_tvalid & bus.s_axis_tready;
    p_ii         = bus.xi * bus.yi;
    p_qq         = bus.xq * bus.yq;
    p_qi         = bus.xq * bus.yi;
    p_iq         = bus.xi * bus.yq;
    acc_i_next   = acc_i + acc_bits'(p_ii) + acc_bits'(p_qq);
    acc_q_next   = acc_q + acc_bits'(p_qi) - acc_bits'(p_iq);
    wide_i       = mag_bits'(acc_i);
    wide_q       = mag_bits'(acc_q);
    mag_calc     = $unsigned(wide_i * wide_i) + $unsigned(wide_q * wide_q);
    take_new     = (lag == '0) || (mag > max_mag);
    best_mag     = take_new ? mag : max_mag;
    best_idx     = take_new ? lag : max_idx;
    best_shifted = best_mag >> out_shift;
    best_sat     = (|best_shifted[mag_bits-1:out_max_bits]) ? '1
                                                            : best_shifted[out_max_bits-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      acc_i             <= '0;
      acc_q             <= '0;
      sample_cnt        <= '0;
      lag               <= '0;
      mag               <= '0;
      max_mag           <= '0;
      max_idx           <= '0;
      bus.s_axis_tready <= 1'b0;
      bus.s_axis_tvalid <= 1'b0;
      bus.out_max       <= '0;
      bus.index         <= '0;
      bus.busy          <= 1'b0;
`ifdef THRESHOLD_DETECT_EN
      bus.detect        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          bus.s_axis_tready <= 1'b1;
          if (accept) begin
            acc_i    <= acc_i_next;
            acc_q    <= acc_q_next;
            bus.busy <= 1'b1;
            if (sample_cnt == last_sample) begin
              sample_cnt        <= '0;
              bus.s_axis_tready <= 1'b0;
              state             <= MAG1;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
              state      <= ACCUM;
            end
          end
        end
        MAG1: begin
          mag   <= mag_calc;
          acc_i <= '0;
          acc_q <= '0;
          state <= MAG2;
        end
        MAG2: begin
          max_mag <= best_mag;
          max_idx <= best_idx;
          if (lag == last_lag) begin
            lag               <= '0;
            bus.out_max       <= best_sat;
            bus.index         <= best_idx;
            bus.s_axis_tvalid <= 1'b1;
            bus.busy          <= 1'b0;
`ifdef THRESHOLD_DETECT_EN
            bus.detect        <= (best_sat >= bus.threshold);
`endif
            state             <= DONE;
          end else begin
            lag               <= lag + 1'b1;
            bus.s_axis_tready <= 1'b1;
            state             <= ACCUM;
          end
        end
        DONE: begin
          if (bus.m_axis_tready) begin
            bus.s_axis_tvalid <= 1'b0;
`ifdef THRESHOLD_DETECT_EN
            bus.detect        <= 1'b0;
`endif
            max_mag           <= '0;
            max_idx           <= '0;
            bus.s_axis_tready <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
